// File: rtl/ofifo_deskew_pkg.sv
// Shared defaults and pointer-width helper for the output deskew FIFO.
package ofifo_deskew_pkg;

  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned COL     = 8;
  localparam int unsigned DEPTH   = 16;

  // Extra MSB is the wrap bit that separates full from empty.
  function automatic int unsigned ptr_w(int unsigned d);
    return $clog2(d) + 1;
  endfunction

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  typedef enum logic {
    MODE_WS = 1'b0,
    MODE_OS = 1'b1
  } mode_e;

endpackage

// File: rtl/ofifo_deskew_if.sv
// Psum write/read bus between the MAC array, the deskew FIFO and write-back.
interface ofifo_deskew_if
  import ofifo_deskew_pkg::*;
#(
  parameter int unsigned COL_N  = COL,
  parameter int unsigned PSUM_W = PSUM_BW
);

  logic                      mode;
  logic [PSUM_W*COL_N-1:0]   in_ws;
  logic [PSUM_W*COL_N-1:0]   in_os;
  logic [COL_N-1:0]          wr;
  logic                      rd;
  logic [PSUM_W*COL_N-1:0]   out;
  logic                      o_valid;
  logic                      o_full;
  logic                      o_ready;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output mode, in_ws, in_os, wr, rd,
    input  out, o_valid, o_full, o_ready, overflow, underflow
  );

  modport slave (
    input  mode, in_ws, in_os, wr, rd,
    output out, o_valid, o_full, o_ready, overflow, underflow
  );

endinterface

// File: rtl/ofifo_lane.sv
// Single-column first-word-fall-through FIFO with wrap-bit pointers.
module ofifo_lane
  import ofifo_deskew_pkg::*;
#(
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] in,
  input  logic               rd,
  output logic [psum_bw-1:0] out,
  output logic               empty,
  output logic               full,
  output logic               drop
);

  localparam int unsigned PW = ptr_w(depth);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [psum_bw-1:0] mem [depth];
  logic               push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // rd arrives pre-gated by the top, so a full lane can accept a push while it pops.
  assign push = wr && (!full || rd);
  assign drop = wr && full && !rd;
  assign out  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (rd)   rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr[AW-1:0]] <= in;
  end

endmodule

// File: rtl/ofifo_deskew.sv
// Per-column psum FIFOs that re-align the array's skewed output into whole rows.
module ofifo_deskew
  import ofifo_deskew_pkg::*;
#(
  parameter int unsigned col     = COL,
  parameter int unsigned psum_bw = PSUM_BW,
  parameter int unsigned depth   = DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  ofifo_deskew_if.slave  bus
);

  logic [col-1:0]         lane_empty;
  logic [col-1:0]         lane_full;
  logic [col-1:0]         lane_drop;
  logic [psum_bw-1:0]     lane_out [col];
  logic [psum_bw*col-1:0] row;
  logic                   valid;
  logic                   pop;
  logic                   overflow_q;
  logic                   underflow_q;

  assign valid = ~|lane_empty;
  assign pop   = bus.rd && valid;

  for (genvar c = 0; c < col; c++) begin : g_lane
    logic [psum_bw-1:0] din;

    assign din = (bus.mode == MODE_OS) ? bus.in_os[psum_bw*c +: psum_bw]
                                       : bus.in_ws[psum_bw*c +: psum_bw];

    ofifo_lane #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (bus.wr[c]),
      .in    (din),
      .rd    (pop),
      .out   (lane_out[c]),
      .empty (lane_empty[c]),
      .full  (lane_full[c]),
      .drop  (lane_drop[c])
    );
  end

  always_comb begin
    row = '0;
    if (valid) begin
      for (int unsigned c = 0; c < col; c++) row[psum_bw*c +: psum_bw] = lane_out[c];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (|lane_drop)          overflow_q  <= 1'b1;
      if (bus.rd && !valid)    underflow_q <= 1'b1;
    end
  end

  assign bus.out       = row;
  assign bus.o_valid   = valid;
  assign bus.o_full    = |lane_full;
  assign bus.o_ready   = ~|lane_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
